// File: rtl/ycbcr_seq_converter_if.sv
`default_nettype none
// ============================================================================
// Module   : ycbcr_seq_converter_if
// Purpose  : Bundles the pixel input handshake, the shared coefficient
//            multiplier bus and the Y/Cb/Cr output handshake of the
//            sequential colour converter.
// Ports    : in_valid/in_ready/r_in/g_in/b_in  - RGB pixel handshake
//            mul_data/mul_coef/mul_result      - external LUT multiplier
//            out_valid/out_ready/y_out/cb_out/cr_out - result handshake
//            busy                              - converter is working
// Modports : master - converter side, slave - surrounding system side
// Revision : 1.0 - initial release
// ============================================================================
interface ycbcr_seq_converter_if #(
  parameter int FIXED_POINT_LENGTH = 32
);
  logic                          in_valid;
  logic                          in_ready;
  logic [7:0]                    r_in;
  logic [7:0]                    g_in;
  logic [7:0]                    b_in;
  logic [7:0]                    mul_data;
  logic [3:0]                    mul_coef;
  logic [FIXED_POINT_LENGTH-1:0] mul_result;
  logic                          out_valid;
  logic                          out_ready;
  logic [7:0]                    y_out;
  logic [7:0]                    cb_out;
  logic [7:0]                    cr_out;
  logic                          busy;

  modport master (
    input  in_valid, r_in, g_in, b_in, mul_result, out_ready,
    output in_ready, mul_data, mul_coef, out_valid, y_out, cb_out, cr_out, busy
  );

  modport slave (
    output in_valid, r_in, g_in, b_in, mul_result, out_ready,
    input  in_ready, mul_data, mul_coef, out_valid, y_out, cb_out, cr_out, busy
  );
endinterface
`default_nettype wire

// File: rtl/ycbcr_seq_converter.sv
`default_nettype none
// ============================================================================
// Module   : ycbcr_seq_converter
// Purpose  : Converts one 8-bit RGB pixel to 8-bit Y/Cb/Cr by time-sharing a
//            single external zero-latency LUT multiplier over 11 steps.
//            Partial products are accumulated in signed fixed point, then
//            rounded, shifted down and clamped to [0,255] per channel.
// Ports    : clk   - system clock, rising edge
//            rst_n - asynchronous active-low reset
//            bus   - ycbcr_seq_converter_if.master (pixel in, multiplier,
//                    result out, busy)
// Revision : 1.0 - initial release
// ============================================================================
module ycbcr_seq_converter #(
  parameter int INPUT_WIDTH        = 8,
  parameter int FIXED_POINT_LENGTH = 32,
  parameter int SCALE              = 16,
  parameter int ACC_WIDTH          = FIXED_POINT_LENGTH + 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ycbcr_seq_converter_if.master  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] LAST_STEP = 4'd10;

  // Half an LSB of the integer result, added before the shift for rounding.
  localparam logic signed [ACC_WIDTH-1:0] ROUND_HALF =
    {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (SCALE-1);

  logic [1:0]                   state_q, state_d;
  logic [3:0]                   step_q, step_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [INPUT_WIDTH-1:0]       r_q, r_d, g_q, g_d, b_q, b_d;
  logic [7:0]                   y_q, y_d, cb_q, cb_d, cr_q, cr_d;

  logic [3:0]                   step_coef;
  logic [INPUT_WIDTH-1:0]       step_operand;
  logic                         step_sub;
  logic                         step_final;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic signed [ACC_WIDTH-1:0]  rounded;
  logic signed [ACC_WIDTH-1:0]  shifted;
  logic [7:0]                   clamped;

  // Step schedule: Y over steps 0-2, Cb over 3-6, Cr over 7-10. Coefficient 8
  // is the +128 chroma offset; its operand is zero.
  always_comb begin
    step_coef    = 4'd0;
    step_operand = '0;
    step_sub     = 1'b0;
    step_final   = 1'b0;
    case (step_q)
      4'd0:  begin step_coef = 4'd0; step_operand = r_q; end
      4'd1:  begin step_coef = 4'd1; step_operand = g_q; end
      4'd2:  begin step_coef = 4'd2; step_operand = b_q; step_final = 1'b1; end
      4'd3:  begin step_coef = 4'd3; step_operand = r_q; step_sub = 1'b1; end
      4'd4:  begin step_coef = 4'd4; step_operand = g_q; step_sub = 1'b1; end
      4'd5:  begin step_coef = 4'd5; step_operand = b_q; end
      4'd6:  begin step_coef = 4'd8; step_final = 1'b1; end
      4'd7:  begin step_coef = 4'd5; step_operand = r_q; end
      4'd8:  begin step_coef = 4'd6; step_operand = g_q; step_sub = 1'b1; end
      4'd9:  begin step_coef = 4'd7; step_operand = b_q; step_sub = 1'b1; end
      4'd10: begin step_coef = 4'd8; step_final = 1'b1; end
      default: begin step_coef = 4'd0; end
    endcase
  end

  // The multiplier result is an unsigned magnitude; the sign comes from the
  // step schedule.
  always_comb begin
    prod_ext = $signed({{(ACC_WIDTH-FIXED_POINT_LENGTH){1'b0}}, bus.mul_result});
    sum      = step_sub ? (acc_q - prod_ext) : (acc_q + prod_ext);
    rounded  = sum + ROUND_HALF;
    shifted  = rounded >>> SCALE;
    if (shifted[ACC_WIDTH-1]) begin
      clamped = 8'd0;
    end else if (|shifted[ACC_WIDTH-2:8]) begin
      clamped = 8'hFF;
    end else begin
      clamped = shifted[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    y_d     = y_q;
    cb_d    = cb_q;
    cr_d    = cr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          r_d     = bus.r_in;
          g_d     = bus.g_in;
          b_d     = bus.b_in;
          acc_d   = '0;
          step_d  = 4'd0;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (step_final) begin
          acc_d = '0;
          case (step_q)
            4'd2:    y_d  = clamped;
            4'd6:    cb_d = clamped;
            default: cr_d = clamped;
          endcase
        end else begin
          acc_d = sum;
        end
        if (step_q == LAST_STEP) begin
          step_d  = 4'd0;
          state_d = ST_DONE;
        end else begin
          step_d  = step_q + 4'd1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      step_q  <= 4'd0;
      acc_q   <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      y_q     <= 8'd0;
      cb_q    <= 8'd0;
      cr_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      y_q     <= y_d;
      cb_q    <= cb_d;
      cr_q    <= cr_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.mul_coef  = (state_q == ST_CALC) ? step_coef : 4'd0;
  assign bus.mul_data  = (state_q == ST_CALC) ? step_operand : 8'd0;
  assign bus.y_out     = y_q;
  assign bus.cb_out    = cb_q;
  assign bus.cr_out    = cr_q;

endmodule
`default_nettype wire

// File: tb/tb_ycbcr_seq_converter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ycbcr_seq_converter
// Purpose  : Self-checking bench for ycbcr_seq_converter. Provides the
//            zero-latency LUT multiplier and compares results against the
//            JPEG RGB->YCbCr equations evaluated with integer arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ycbcr_seq_converter;

  logic clk;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_accept;
  int   last_y, last_cb, last_cr;

  // JPEG coefficients in Q16: 0.299 0.587 0.114 0.168736 0.331264 0.5
  // 0.418688 0.081312, then the +128 offset entry.
  int K [0:8] = '{19595, 38470, 7471, 11058, 21710, 32768, 27439, 5329, 8388608};

  ycbcr_seq_converter_if #(.FIXED_POINT_LENGTH(32)) bus ();

  ycbcr_seq_converter #(
    .INPUT_WIDTH(8), .FIXED_POINT_LENGTH(32), .SCALE(16), .ACC_WIDTH(34)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External multiplier: product of operand and selected coefficient.
  always_comb begin
    if (bus.mul_coef == 4'd8)
      bus.mul_result = 32'(K[8]);
    else if (bus.mul_coef < 4'd8)
      bus.mul_result = 32'(int'(bus.mul_data) * K[bus.mul_coef]);
    else
      bus.mul_result = 32'd0;
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rnd_clamp(input int x);
    int v;
    v = (x + 32768) >>> 16;
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // Converts one pixel; hold = cycles of out_ready=0 once the result is up,
  // keep = leave in_valid high afterwards (next call follows immediately).
  task automatic convert(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input int hold, input bit keep);
    int n;
    logic [43:0] seq;
    int ey, ecb, ecr;
    logic [23:0] held;
    ey  = rnd_clamp(K[0]*int'(r) + K[1]*int'(g) + K[2]*int'(b));
    ecb = rnd_clamp(-K[3]*int'(r) - K[4]*int'(g) + K[5]*int'(b) + K[8]);
    ecr = rnd_clamp(K[5]*int'(r) - K[6]*int'(g) - K[7]*int'(b) + K[8]);
    bus.in_valid  = 1'b1;
    bus.r_in      = r;
    bus.g_in      = g;
    bus.b_in      = b;
    bus.out_ready = (hold == 0);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_before_accept", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    last_accept  = cyc;
    bus.in_valid = keep;
    bus.r_in     = 8'($urandom);
    bus.g_in     = 8'($urandom);
    bus.b_in     = 8'($urandom);
    check_eq("busy_in_calc", {bus.busy, bus.in_ready}, 2'b10);
    seq = '0;
    n = 0;
    while (!bus.out_valid && n < 30) begin
      seq = {seq[39:0], bus.mul_coef};
      @(negedge clk);
      n++;
    end
    check_eq("latency", n, 11);
    check_eq("coef_seq", seq, 44'h01234585678);
    check_eq("y", bus.y_out, ey);
    check_eq("cb", bus.cb_out, ecb);
    check_eq("cr", bus.cr_out, ecr);
    check_eq("mul_idle_in_done", {bus.mul_data, bus.mul_coef}, 0);
    last_y  = bus.y_out;
    last_cb = bus.cb_out;
    last_cr = bus.cr_out;
    held = {bus.y_out, bus.cb_out, bus.cr_out};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_data", {bus.y_out, bus.cb_out, bus.cr_out}, held);
      check_eq("hold_valid_ready", {bus.out_valid, bus.in_ready}, 2'b10);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("post_handshake", {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
  endtask

  initial begin
    int a1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.r_in      = 8'd0;
    bus.g_in      = 8'd0;
    bus.b_in      = 8'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs",
             {bus.out_valid, bus.busy, bus.mul_data, bus.mul_coef,
              bus.y_out, bus.cb_out, bus.cr_out}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("reset_in_ready", bus.in_ready, 1);

    convert(8'd255, 8'd255, 8'd255, 0, 0);
    check_eq("white", {last_y[7:0], last_cb[7:0], last_cr[7:0]}, {8'd255, 8'd128, 8'd128});
    convert(8'd0, 8'd0, 8'd0, 0, 0);
    check_eq("black", {last_y[7:0], last_cb[7:0], last_cr[7:0]}, {8'd0, 8'd128, 8'd128});
    convert(8'd255, 8'd0, 8'd0, 0, 0);
    check_eq("red", {last_y[7:0], last_cb[7:0], last_cr[7:0]}, {8'd76, 8'd85, 8'd255});
    convert(8'd0, 8'd0, 8'd255, 0, 0);
    check_eq("blue", {last_y[7:0], last_cb[7:0], last_cr[7:0]}, {8'd29, 8'd255, 8'd107});

    // Back-pressure with in_valid held high, then minimum pixel period.
    convert(8'd10, 8'd200, 8'd30, 20, 1);
    a1 = last_accept;
    convert(8'd90, 8'd60, 8'd240, 0, 1);
    check_eq("period_backpressure", last_accept - a1, 33);
    a1 = last_accept;
    convert(8'd128, 8'd64, 8'd32, 0, 0);
    check_eq("period_min", last_accept - a1, 13);

    for (int i = 0; i < 12; i++) begin
      convert(8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    bus.in_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of a conversion.
    bus.in_valid = 1'b1;
    bus.r_in = 8'd200; bus.g_in = 8'd100; bus.b_in = 8'd50;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("mid_step5_coef", bus.mul_coef, 5);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset_outputs",
             {bus.out_valid, bus.busy, bus.mul_data, bus.mul_coef,
              bus.y_out, bus.cb_out, bus.cr_out}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("after_reset_ready", {bus.in_ready, bus.out_valid}, 2'b10);
    convert(8'd17, 8'd250, 8'd99, 0, 0);
    convert(8'($urandom), 8'($urandom), 8'($urandom), 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
